// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over GATE_CYCLES clk cycles.
// Optional build macro FREQ_METER_GLITCH_FILTER_EN adds a 3-cycle stability filter after the synchronizer.
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 100000000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_out,
   output logic             valid,
   output logic             overflow,
   output logic             busy
);
   typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

   localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic             lvl_q, lvl_d, rise;
   logic [31:0]      gate_q, gate_d;
   logic [CNT_W-1:0] edge_q, edge_d, edge_inc;
   logic [CNT_W-1:0] freq_q, freq_d;
   logic             sat_q, sat_d, sat_inc;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

`ifdef FREQ_METER_GLITCH_FILTER_EN
   // hist_q holds the two previous synced samples; the level follows only after 3 equal samples.
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (!reset) hist_q <= '0;
      else        hist_q <= {hist_q[0], sync_q[1]};
   end

   always_comb begin
      lvl_d = lvl_q;
      if (sync_q[1] == hist_q[0] && sync_q[1] == hist_q[1]) lvl_d = sync_q[1];
   end
`else
   assign lvl_d = sync_q[1];
`endif

   // Edge is taken from the next level so the filter only adds its 2 stability cycles of latency.
   assign rise     = lvl_d & ~lvl_q;
   assign edge_inc = (rise && edge_q != CNT_MAX) ? edge_q + CNT_W'(1) : edge_q;
   assign sat_inc  = sat_q | (rise && edge_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         sync_q  <= '0;
         lvl_q   <= 1'b0;
         gate_q  <= '0;
         edge_q  <= '0;
         sat_q   <= 1'b0;
         freq_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], sig_in};
         lvl_q   <= lvl_d;
         gate_q  <= gate_d;
         edge_q  <= edge_d;
         sat_q   <= sat_d;
         freq_q  <= freq_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      edge_d  = edge_q;
      sat_d   = sat_q;
      freq_d  = freq_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = MEASURE;
               gate_d  = '0;
               edge_d  = '0;
               sat_d   = 1'b0;
            end
         end
         MEASURE: begin
            if (gate_q == GATE_LAST) begin
               // Window closes even if en drops on this cycle; the closing-cycle edge belongs here.
               freq_d  = edge_inc;
               ovf_d   = sat_inc;
               valid_d = 1'b1;
               gate_d  = '0;
               edge_d  = '0;
               sat_d   = 1'b0;
               state_d = en ? MEASURE : IDLE;
            end else if (!en) begin
               state_d = IDLE;
               gate_d  = '0;
               edge_d  = '0;
               sat_d   = 1'b0;
            end else begin
               gate_d = gate_q + 32'd1;
               edge_d = edge_inc;
               sat_d  = sat_inc;
            end
         end
      endcase
   end

   assign freq_out = freq_q;
   assign overflow = ovf_q;
   assign valid    = valid_q;
   assign busy     = (state_q == MEASURE);
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a CNT_W=8 instance for count/abort/reset/boundary/glitch cases and a CNT_W=4 one for saturation.
module tb_freq_meter;
  localparam int GATE = 100;
`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam int LAT_F   = 2;
  localparam int GLITCH  = 0;
  localparam int SAT_PER = 6;
  localparam int SAT_HI  = 3;
`else
  localparam int LAT_F   = 0;
  localparam int GLITCH  = 10;
  localparam int SAT_PER = 2;
  localparam int SAT_HI  = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset, en, sig_in;
  logic [7:0] freq_out;
  logic       valid, overflow, busy;
  logic       s_reset, s_en, s_sig;
  logic [3:0] s_freq;
  logic       s_valid, s_ovf, s_busy;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
    .freq_out(freq_out), .valid(valid), .overflow(overflow), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) u_sat (
    .clk(clk), .reset(s_reset), .en(s_en), .sig_in(s_sig),
    .freq_out(s_freq), .valid(s_valid), .overflow(s_ovf), .busy(s_busy)
  );

  // waveform generators: update 2 ns after each rising edge
  int   per = 0, hiw = 0, ph = 0;
  logic man = 1'b0;
  int   s_per = 0, s_hiw = 0, s_ph = 0;
  initial begin sig_in = 1'b0; s_sig = 1'b0; end

  always begin
    @(posedge clk);
    #2;
    if (per == 0) sig_in = man;
    else begin sig_in = (ph < hiw); ph = (ph + 1) % per; end
    if (s_per == 0) s_sig = 1'b0;
    else begin s_sig = (s_ph < s_hiw); s_ph = (s_ph + 1) % s_per; end
  end

  // scoreboard
  int n_cmp = 0, n_err = 0;
  logic [40:0] exp_q[$];    // {valid cycle, overflow, freq_out}
  logic [36:0] s_exp_q[$];
  logic        sat_done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_wave(input int p, input int h);
    per = p; hiw = h; ph = 0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // monitors
  always @(negedge clk) begin
    logic [40:0] e;
    logic [36:0] se;
    if (valid) begin
      if (exp_q.size() == 0) check("main_unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("main_valid_cycle", cyc, e[40:9]);
        check("main_freq_out", freq_out, e[7:0]);
        check("main_overflow", overflow, e[8]);
      end
    end
    if (s_valid) begin
      if (s_exp_q.size() == 0) check("sat_unexpected_valid", 1, 0);
      else begin
        se = s_exp_q.pop_front();
        check("sat_valid_cycle", cyc, se[36:5]);
        check("sat_freq_out", s_freq, se[3:0]);
        check("sat_overflow", s_ovf, se[4]);
      end
    end
  end

  // saturation instance driver
  initial begin
    int k;
    s_reset = 1'b0; s_en = 1'b0;
    s_per = SAT_PER; s_hiw = SAT_HI; s_ph = 0;
    repeat (3) @(negedge clk);
    check("sat_rst_freq", s_freq, 0);
    check("sat_rst_busy", s_busy, 0);
    s_reset = 1'b1;
    repeat (5) @(negedge clk);
    s_en = 1'b1; k = cyc;
    s_exp_q.push_back({32'(k + 101), 1'b1, 4'd15});
    wait_until(k + 101);
    s_en = 1'b0;
    s_per = 10; s_hiw = 5; s_ph = 0;
    repeat (20) @(negedge clk);
    check("sat_hold_freq", s_freq, 15);
    check("sat_hold_ovf", s_ovf, 1);
    s_en = 1'b1; k = cyc;
    s_exp_q.push_back({32'(k + 101), 1'b0, 4'd10});
    wait_until(k + 101);
    s_en = 1'b0;
    repeat (3) @(negedge clk);
    sat_done = 1'b1;
  end

  // main instance driver
  initial begin
    int k, a, x, w;
    reset = 1'b0; en = 1'b0;
    set_wave(10, 5);
    repeat (3) @(negedge clk);
    check("rst_freq_out", freq_out, 0);
    check("rst_valid", valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    // three abutting windows at period 10
    en = 1'b1; k = cyc;
    for (int i = 1; i <= 3; i++) exp_q.push_back({32'(k + 1 + 100 * i), 1'b0, 8'd10});
    @(negedge clk);
    check("measure_busy", busy, 1);

    // abort at gate_cnt 50 of the fourth window, re-enable 20 cycles later
    wait_until(k + 1 + 300 + 50);
    en = 1'b0; a = cyc;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hold_freq", freq_out, 10);
    wait_until(a + 20);
    check("idle_hold_freq", freq_out, 10);
    check("idle_hold_ovf", overflow, 0);
    en = 1'b1; k = cyc;
    exp_q.push_back({32'(k + 101), 1'b0, 8'd10});

    // reset pulse at gate_cnt 70 of the following window, input quiet around it
    wait_until(k + 1 + 160);
    set_wave(0, 0);
    wait_until(k + 1 + 170);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_freq_out", freq_out, 0);
    check("midrst_valid", valid, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b1; x = cyc;
    set_wave(10, 5);
    exp_q.push_back({32'(x + 101), 1'b0, 8'd10});

    // single edge landing on the gate_cnt==99 cycle of window W
    wait_until(x + 96);
    set_wave(0, 0);
    w = x + 101;
    exp_q.push_back({32'(w + 100), 1'b0, 8'd1});
    exp_q.push_back({32'(w + 200), 1'b0, 8'd0});
    wait_until(w + 96 - LAT_F);
    man = 1'b1;
    wait_until(w + 102 - LAT_F);
    man = 1'b0;
    wait_until(w + 200);
    en = 1'b0;

    // 1-clk glitches every 10 cycles
    set_wave(10, 1);
    repeat (30) @(negedge clk);
    en = 1'b1; k = cyc;
    exp_q.push_back({32'(k + 101), 1'b0, 8'(GLITCH)});
    wait_until(k + 101);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_idle_busy", busy, 0);

    for (int i = 0; i < 500 && !sat_done; i++) @(negedge clk);
    check("sat_thread_done", sat_done, 1);
    check("main_pending", exp_q.size(), 0);
    check("sat_pending", s_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, is the gate window length in clk cycles (1 s at 100 MHz); legal range 2..2^32-1.
REQ-002 Parameter CNT_W, default 27, is the width of the edge counter and of freq_out.
REQ-003 clk  input  1  system clock, 100 MHz nominal; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 en  input  1  measurement enable, synchronous to clk.
REQ-006 sig_in  input  1  signal under measurement, asynchronous to clk.
REQ-007 freq_out  output  CNT_W  rising-edge count from the last completed window (Hz when GATE_CYCLES equals the clk rate).
REQ-008 valid  output  1  one-cycle pulse when freq_out is updated.
REQ-009 overflow  output  1  the edge count in the last completed window saturated.
REQ-010 busy  output  1  high while a window is in progress.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is synced=1 while the previous synced value was 0.
REQ-012 The FSM SHALL have two states, IDLE and MEASURE; busy=1 exactly in MEASURE.
REQ-013 IDLE->MEASURE on the first cycle en=1; gate_cnt and edge_cnt are 0 on entry.
REQ-014 In MEASURE, gate_cnt SHALL increment once per cycle from 0 to GATE_CYCLES-1.
REQ-015 In MEASURE, edge_cnt SHALL increment on each detected rising edge and saturate at 2^CNT_W-1 without wrapping.
REQ-016 On the cycle where gate_cnt==GATE_CYCLES-1, the next clk edge SHALL do all of the following:
  - load freq_out with edge_cnt plus any edge in that cycle (saturating);
  - assert valid for one cycle;
  - load overflow with the saturation status;
  - clear gate_cnt and edge_cnt.
REQ-017 After a window closes, if en=1 the next window SHALL start with no dead cycle, so back-to-back windows abut; if en=0 the FSM SHALL return to IDLE.
REQ-018 en=0 mid-window SHALL abort it: return to IDLE and discard the counts; valid does not pulse; freq_out and overflow hold their values.
REQ-019 An edge on the same cycle as window close SHALL count in the closing window, never in the next one.
REQ-020 freq_out and overflow SHALL hold between valid pulses.
REQ-021 Edges detected in IDLE SHALL be ignored.

Reset
REQ-022 While reset=0 at a clk edge, the FSM SHALL enter IDLE and clear these to 0: freq_out, valid, overflow, busy, gate_cnt, edge_cnt and the synchronizer/filter flops.
REQ-023 Reset asserted mid-window SHALL abort the window with no valid pulse; measurement resumes only after reset=1 and en=1.

Configuration
REQ-024 With macro FREQ_METER_GLITCH_FILTER_EN defined, a 3-cycle stability filter SHALL follow the synchronizer.
  - The filtered level changes only after the synced value has been stable for 3 consecutive cycles.
  - Edge detection uses the filtered level.
  - Pulses shorter than 3 clk cycles are not counted; input-to-detect latency rises by 2 cycles.
REQ-025 Without FREQ_METER_GLITCH_FILTER_EN, edge detection SHALL use the synchronized value directly; the filter logic is absent.

Verification (GATE_CYCLES=100, CNT_W=8 unless stated)
REQ-026 Basic count: reset, en=1, sig_in square wave period 10 clk -> every valid shows freq_out=10, overflow=0; valid pulses exactly 100 cycles apart.
REQ-027 Saturation: CNT_W=4, sig_in period 2 clk (50 edges/window) -> freq_out=15, overflow=1; next window at period 10 -> freq_out=10, overflow=0.
REQ-028 Abort: en=1 with period-10 input, drop en at gate_cnt=50, raise again 20 cycles later -> no valid at abort; freq_out keeps prior value; next valid occurs 100 cycles after re-entry with freq_out=10.
REQ-029 Reset mid-window: reset=0 for 1 cycle at gate_cnt=70 -> all outputs 0 next cycle, no valid; with en held at 1, next valid 101 cycles after reset release (1 IDLE->MEASURE cycle plus the 100-cycle window).
REQ-030 Boundary edge: synced rising edge on the gate_cnt==99 cycle -> counted in the closing window's freq_out and not in the next.
REQ-031 Glitch: 1-clk-wide pulses every 10 cycles -> freq_out=10 without FREQ_METER_GLITCH_FILTER_EN; freq_out=0 with it defined.
